// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_CLEAR
  } state_e;

  localparam logic [7:0]  ADDR_BAUD_DEF  = 8'h00;
  localparam logic [7:0]  ADDR_TX_DEF    = 8'h04;
  localparam logic [7:0]  ADDR_TX_EN_DEF = 8'h0C;
  localparam logic [31:0] BAUD_DIV_DEF   = 32'd868;
  localparam logic [31:0] TX_EN_ON       = 32'd1;
  localparam logic [31:0] TX_EN_OFF      = 32'd0;

endpackage

// File: rtl/uart_sched_fifo.sv
// Synchronous byte FIFO with push, pop, flush and occupancy count.
module uart_sched_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;

  // flush wins over a same-cycle push or pop
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign full_o  = (level == (AW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Sequences uart_core register writes: baud init, then per-byte load/enable/wait/disable.
// Define UART_TX_SCHED_STATS_EN to add the tx_count_o completed-frame counter.
//   state | meaning
//   INIT  | write baud divisor once after reset
//   IDLE  | wait for a queued byte and a low TX interrupt
//   LOAD  | write head byte to TX data register, pop FIFO
//   START | write TX enable = 1, clear wait counter
//   WAIT  | wait for TX interrupt or timeout
//   CLEAR | write TX enable = 0
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BAUD_DIV   = BAUD_DIV_DEF,
  parameter logic [7:0]  ADDR_BAUD  = ADDR_BAUD_DEF,
  parameter logic [7:0]  ADDR_TX    = ADDR_TX_DEF,
  parameter logic [7:0]  ADDR_TX_EN = ADDR_TX_EN_DEF,
  parameter logic [19:0] TIMEOUT    = 20'd100000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_valid_i,
  input  logic [7:0]                    push_data_i,
  output logic                          push_ready_o,
  input  logic                          flush_i,
  output logic                          uart_we_o,
  output logic                          uart_ren_o,
  output logic [7:0]                    uart_addr_o,
  output logic [31:0]                   uart_wdata_o,
  input  logic                          uart_intr_tx_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_timeout_o
`ifdef UART_TX_SCHED_STATS_EN
  ,
  output logic [15:0]                   tx_count_o
`endif
);

  state_e      state;
  logic [19:0] wait_cnt;
  logic [7:0]  head;
  logic        fifo_full;
  logic        fifo_empty;

  uart_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_valid_i),
    .push_data_i (push_data_i),
    .pop_i       (state == ST_LOAD),
    .flush_i     (flush_i),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  assign push_ready_o = !fifo_full;
  assign uart_ren_o   = 1'b0;
  assign busy_o       = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_INIT;
      uart_we_o     <= 1'b0;
      uart_addr_o   <= '0;
      uart_wdata_o  <= '0;
      wait_cnt      <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      uart_we_o    <= 1'b0;
      uart_addr_o  <= '0;
      uart_wdata_o <= '0;
      case (state)
        ST_INIT: begin
          uart_we_o    <= 1'b1;
          uart_addr_o  <= ADDR_BAUD;
          uart_wdata_o <= BAUD_DIV;
          state        <= ST_IDLE;
        end
        ST_IDLE: begin
          // a stale interrupt from a previous frame holds off the next load
          if (!fifo_empty && !uart_intr_tx_i) state <= ST_LOAD;
        end
        ST_LOAD: begin
          uart_we_o    <= 1'b1;
          uart_addr_o  <= ADDR_TX;
          uart_wdata_o <= {24'h0, head};
          state        <= ST_START;
        end
        ST_START: begin
          uart_we_o    <= 1'b1;
          uart_addr_o  <= ADDR_TX_EN;
          uart_wdata_o <= TX_EN_ON;
          wait_cnt     <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (uart_intr_tx_i) begin
            state <= ST_CLEAR;
          end else if (wait_cnt == TIMEOUT - 20'd1) begin
            err_timeout_o <= 1'b1;
            state         <= ST_CLEAR;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
        end
        ST_CLEAR: begin
          uart_we_o    <= 1'b1;
          uart_addr_o  <= ADDR_TX_EN;
          uart_wdata_o <= TX_EN_OFF;
          state        <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef UART_TX_SCHED_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_count_o <= '0;
    end else if (state == ST_WAIT && uart_intr_tx_i) begin
      tx_count_o <= tx_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: random pushes against a queue-based transaction model.
module tb_uart_tx_sched;

  localparam int          DEPTH   = 8;
  localparam logic [7:0]  A_BAUD  = 8'h00;
  localparam logic [7:0]  A_TX    = 8'h04;
  localparam logic [7:0]  A_EN    = 8'h0C;
  localparam logic [31:0] BAUD    = 32'd868;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic        push_ready;
  logic        flush = 1'b0;
  logic        uart_we;
  logic        uart_ren;
  logic [7:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic        intr_auto = 1'b0;
  logic        intr_stale = 1'b0;
  logic        uart_intr;
  logic        busy;
  logic [3:0]  level;
  logic        err_timeout;
`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] tx_count;
`endif

  assign uart_intr = intr_auto | intr_stale;

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT(20'd16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_n),
    .push_valid_i   (push_valid),
    .push_data_i    (push_data),
    .push_ready_o   (push_ready),
    .flush_i        (flush),
    .uart_we_o      (uart_we),
    .uart_ren_o     (uart_ren),
    .uart_addr_o    (uart_addr),
    .uart_wdata_o   (uart_wdata),
    .uart_intr_tx_i (uart_intr),
    .busy_o         (busy),
    .fifo_level_o   (level),
    .err_timeout_o  (err_timeout)
`ifdef UART_TX_SCHED_STATS_EN
    ,
    .tx_count_o     (tx_count)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] mq [$];
  wr_t exp_q [$];
  int intr_cnt = 0;
  int intr_delay = 10;
  bit rand_delay = 1'b0;
  bit auto_en = 1'b1;
  int en_on_count = 0;
  int tx_writes = 0;
  int last_tx_cyc = 0;
  int last_en_on_cyc = 0;
  int last_push_cyc = 0;
  wr_t mon_e;
  logic [7:0] mon_b;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // monitor: checks every register write against the expected stream, and plays the UART
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (intr_cnt > 0) begin
        intr_cnt--;
        if (intr_cnt == 0) intr_auto = 1'b1;
      end
      if (uart_we) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", uart_addr, mon_e.addr);
          chk("wr_data", uart_wdata, mon_e.data);
        end else if (mq.size() > 0) begin
          mon_b = mq.pop_front();
          chk("tx_addr", uart_addr, A_TX);
          chk("tx_data", uart_wdata, {24'h0, mon_b});
          exp_q.push_back(mk(A_EN, 32'd1));
          exp_q.push_back(mk(A_EN, 32'd0));
          tx_writes++;
          last_tx_cyc = cyc;
        end else begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", uart_addr, uart_wdata);
        end
        chk("ren", uart_ren, 1'b0);
        if (uart_addr == A_EN && uart_wdata == 32'd1) begin
          en_on_count++;
          last_en_on_cyc = cyc;
          if (auto_en) intr_cnt = rand_delay ? int'($urandom_range(1, 12)) : intr_delay;
        end
        if (uart_addr == A_EN && uart_wdata == 32'd0) intr_auto = 1'b0;
      end
      chk("level", level, mq.size());
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    @(negedge clk_i); #1;
    chk("push_ready", push_ready, mq.size() < DEPTH);
    acc = (mq.size() < DEPTH);
    push_valid = 1'b1;
    push_data = b;
    @(posedge clk_i); #1;
    push_valid = 1'b0;
    if (acc) mq.push_back(b);
    last_push_cyc = cyc;
  endtask

  task automatic wait_en_on(input string name);
    int start;
    bit seen;
    start = en_on_count;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i); #1;
      if (en_on_count != start) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_i); #1;
      if (mq.size() == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, done, 1'b1);
  endtask

  initial begin
    #1;
    chk("rst_we", uart_we, 1'b0);
    chk("rst_addr", uart_addr, 8'h00);
    chk("rst_wdata", uart_wdata, 32'h0);
    chk("rst_ready", push_ready, 1'b1);
    chk("rst_err", err_timeout, 1'b0);
    repeat (3) @(negedge clk_i);
    exp_q.push_back(mk(A_BAUD, BAUD));
    #1 rst_n = 1'b1;
    @(negedge clk_i); #1;
    chk("init_we", uart_we, 1'b1);
    chk("init_addr", uart_addr, A_BAUD);
    chk("init_wdata", uart_wdata, BAUD);
    @(negedge clk_i); #1;
    chk("idle_we", uart_we, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // single byte latency
    repeat (2) @(negedge clk_i);
    push_byte(8'hA5);
    drain("drain_single");
    chk("lat_load", last_tx_cyc - last_push_cyc, 2);
    chk("lat_enable", last_en_on_cyc - last_push_cyc, 3);
    chk("no_timeout", err_timeout, 1'b0);

    // stale interrupt holds the FIFO so it fills; 9th push is refused
    @(negedge clk_i); #1;
    intr_stale = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
    @(negedge clk_i); #1;
    chk("full_level", level, 4'd8);
    chk("full_ready", push_ready, 1'b0);
    push_byte(8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      chk("stale_block_we", uart_we, 1'b0);
    end
    intr_stale = 1'b0;
    rand_delay = 1'b1;
    drain("drain_full");

    // random traffic
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_i);
      push_byte(8'($urandom_range(0, 255)));
    end
    drain("drain_random");

    // timeout: interrupt never arrives
    auto_en = 1'b0;
    push_byte(8'h3C);
    wait_en_on("to_enable_seen");
    repeat (15) @(negedge clk_i);
    #1 chk("to_before", err_timeout, 1'b0);
    @(negedge clk_i); #1;
    chk("to_set", err_timeout, 1'b1);
    drain("drain_timeout");
    auto_en = 1'b1;
    rand_delay = 1'b0;
    intr_delay = 10;
    push_byte(8'h42);
    drain("drain_after_to");
    chk("to_sticky", err_timeout, 1'b1);

    // flush while a byte is in flight with three more queued
    @(negedge clk_i); #1;
    intr_stale = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h60 + i));
    @(negedge clk_i); #1;
    intr_stale = 1'b0;
    wait_en_on("fl_enable_seen");
    chk("fl_level_before", level, 4'd3);
    begin
      int txw;
      txw = tx_writes;
      flush = 1'b1;
      push_valid = 1'b1;
      push_data = 8'hEE;
      @(posedge clk_i); #1;
      flush = 1'b0;
      push_valid = 1'b0;
      mq.delete();
      drain("drain_flush");
      chk("fl_no_more_tx", tx_writes, txw);
      chk("fl_level_after", level, 4'd0);
    end

    // reset during WAIT
    push_byte(8'h5A);
    wait_en_on("rs_enable_seen");
    rst_n = 1'b0;
    #1;
    chk("rs_we", uart_we, 1'b0);
    chk("rs_addr", uart_addr, 8'h00);
    chk("rs_wdata", uart_wdata, 32'h0);
    chk("rs_level", level, 4'd0);
    chk("rs_ready", push_ready, 1'b1);
    chk("rs_err", err_timeout, 1'b0);
    mq.delete();
    exp_q.delete();
    intr_cnt = 0;
    intr_auto = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_q.push_back(mk(A_BAUD, BAUD));
    #1 rst_n = 1'b1;
    @(negedge clk_i); #1;
    chk("rs_init_we", uart_we, 1'b1);
    chk("rs_init_addr", uart_addr, A_BAUD);
    push_byte(8'h77);
    drain("drain_after_reset");
    chk("end_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
